// File: rtl/cmp_arbiter_pkg.sv
// +--------------------------------------------------------------------+
// | cmp_arbiter_pkg : op and state encodings for the shared comparator |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none
`ifndef CMP_ARBITER_PKG_SV
`define CMP_ARBITER_PKG_SV
package cmp_arbiter_pkg;

   localparam logic [1:0] CMP_LTU = 2'b00;
   localparam logic [1:0] CMP_LT  = 2'b01;
   localparam logic [1:0] CMP_GEU = 2'b10;
   localparam logic [1:0] CMP_GE  = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_CMP  = 2'b01,
      S_RESP = 2'b10
   } state_t;

endpackage
`endif
`default_nettype wire

// File: rtl/cmp_arbiter_if.sv
// +--------------------------------------------------------------------+
// | cmp_arbiter_if : two request/response channel pairs                |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none
interface cmp_arbiter_if #(
   parameter int WIDTH = 64,
   parameter int TAG_W = 4
);
   logic             req0_valid;
   logic             req0_ready;
   logic [WIDTH-1:0] req0_a;
   logic [WIDTH-1:0] req0_b;
   logic [1:0]       req0_op;
   logic [TAG_W-1:0] req0_tag;
   logic             resp0_valid;
   logic             resp0_ready;
   logic             resp0_result;
   logic [TAG_W-1:0] resp0_tag;

   logic             req1_valid;
   logic             req1_ready;
   logic [WIDTH-1:0] req1_a;
   logic [WIDTH-1:0] req1_b;
   logic [1:0]       req1_op;
   logic [TAG_W-1:0] req1_tag;
   logic             resp1_valid;
   logic             resp1_ready;
   logic             resp1_result;
   logic [TAG_W-1:0] resp1_tag;

   modport master (
      output req0_valid, req0_a, req0_b, req0_op, req0_tag, resp0_ready,
      input  req0_ready, resp0_valid, resp0_result, resp0_tag,
      output req1_valid, req1_a, req1_b, req1_op, req1_tag, resp1_ready,
      input  req1_ready, resp1_valid, resp1_result, resp1_tag
   );

   modport slave (
      input  req0_valid, req0_a, req0_b, req0_op, req0_tag, resp0_ready,
      output req0_ready, resp0_valid, resp0_result, resp0_tag,
      input  req1_valid, req1_a, req1_b, req1_op, req1_tag, resp1_ready,
      output req1_ready, resp1_valid, resp1_result, resp1_tag
   );
endinterface
`default_nettype wire

// File: rtl/cmp_arbiter_slt.sv
// +--------------------------------------------------------------------+
// | set_less_than_unsigned : unsigned magnitude compare, o_lt = a < b  |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none
module set_less_than_unsigned #(
   parameter int WIDTH = 64
) (
   input  wire logic [WIDTH-1:0] i_a,
   input  wire logic [WIDTH-1:0] i_b,
   output logic                  o_lt
);
   assign o_lt = (i_a < i_b);
endmodule
`default_nettype wire

// File: rtl/cmp_arbiter.sv
// +--------------------------------------------------------------------+
// | cmp_arbiter : round-robin sharing of one 64-bit comparator         |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none
module cmp_arbiter
   import cmp_arbiter_pkg::*;
#(
   parameter int WIDTH   = 64,
   parameter int TAG_W   = 4,
   parameter int RR_INIT = 0
) (
   input wire logic     clk,
   input wire logic     rst,
   cmp_arbiter_if.slave bus
);
   localparam logic c_rr_init = (RR_INIT != 0);

   state_t           r_state;
   state_t           w_next;
   logic             r_ptr;
   logic             r_gnt;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [1:0]       r_op;
   logic [TAG_W-1:0] r_tag;
   logic             r_result;

   logic             w_any;
   logic             w_gnt;
   logic             w_accept;
   logic             w_resp_ready;
   logic             w_in_resp;
   logic             w_signed;
   logic             w_invert;
   logic             w_lt;
   logic [WIDTH-1:0] w_a_cmp;
   logic [WIDTH-1:0] w_b_cmp;

   // Under contention the pointer decides; a lone requester wins outright.
   assign w_any        = bus.req0_valid | bus.req1_valid;
   assign w_gnt        = (bus.req0_valid & bus.req1_valid) ? r_ptr : bus.req1_valid;
   assign w_resp_ready = r_gnt ? bus.resp1_ready : bus.resp0_ready;

   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_any) begin
               w_accept = 1'b1;
               w_next   = S_CMP;
            end
         end
         S_CMP:   w_next = S_RESP;
         S_RESP:  if (w_resp_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ptr    <= c_rr_init;
         r_gnt    <= 1'b0;
         r_a      <= '0;
         r_b      <= '0;
         r_op     <= '0;
         r_tag    <= '0;
         r_result <= 1'b0;
      end else begin
         if (w_accept) begin
            r_gnt <= w_gnt;
            r_ptr <= ~w_gnt;
            r_a   <= w_gnt ? bus.req1_a   : bus.req0_a;
            r_b   <= w_gnt ? bus.req1_b   : bus.req0_b;
            r_op  <= w_gnt ? bus.req1_op  : bus.req0_op;
            r_tag <= w_gnt ? bus.req1_tag : bus.req0_tag;
         end
         if (r_state == S_CMP) begin
            r_result <= w_lt ^ w_invert;
         end
      end
   end

   always_comb begin
      w_signed = 1'b0;
      w_invert = 1'b0;
      case (r_op)
         CMP_LTU: begin w_signed = 1'b0; w_invert = 1'b0; end
         CMP_LT:  begin w_signed = 1'b1; w_invert = 1'b0; end
         CMP_GEU: begin w_signed = 1'b0; w_invert = 1'b1; end
         CMP_GE:  begin w_signed = 1'b1; w_invert = 1'b1; end
         default: begin w_signed = 1'b0; w_invert = 1'b0; end
      endcase
   end

   // Flipping the sign bits maps two's-complement order onto unsigned order.
   assign w_a_cmp = {r_a[WIDTH-1] ^ w_signed, r_a[WIDTH-2:0]};
   assign w_b_cmp = {r_b[WIDTH-1] ^ w_signed, r_b[WIDTH-2:0]};

   set_less_than_unsigned #(
      .WIDTH (WIDTH)
   ) u_slt (
      .i_a  (w_a_cmp),
      .i_b  (w_b_cmp),
      .o_lt (w_lt)
   );

   assign w_in_resp = (r_state == S_RESP);

   assign bus.req0_ready   = w_accept & ~w_gnt;
   assign bus.req1_ready   = w_accept &  w_gnt;

   assign bus.resp0_valid  = w_in_resp & ~r_gnt;
   assign bus.resp1_valid  = w_in_resp &  r_gnt;
   assign bus.resp0_result = bus.resp0_valid & r_result;
   assign bus.resp1_result = bus.resp1_valid & r_result;
   assign bus.resp0_tag    = bus.resp0_valid ? r_tag : '0;
   assign bus.resp1_tag    = bus.resp1_valid ? r_tag : '0;

endmodule
`default_nettype wire

// File: tb/tb_cmp_arbiter.sv
// +--------------------------------------------------------------------+
// | tb_cmp_arbiter : directed scoreboard bench for cmp_arbiter         |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none
module tb_cmp_arbiter;
   import cmp_arbiter_pkg::*;

   typedef struct {
      logic       res;
      logic [3:0] tag;
      int         acc;
   } exp_t;

   logic clk;
   logic rst;
   int   tests;
   int   fails;
   int   cyc;
   logic acc0;
   logic acc1;
   exp_t q0[$];
   exp_t q1[$];
   logic pv   [0:1];
   logic pres [0:1];
   logic [3:0] ptag [0:1];

   cmp_arbiter_if #(.WIDTH(64), .TAG_W(4)) bus ();

   cmp_arbiter #(
      .WIDTH   (64),
      .TAG_W   (4),
      .RR_INIT (0)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   function automatic logic model(input logic [63:0] a, input logic [63:0] b, input logic [1:0] op);
      logic lt;
      if (op[0]) lt = ($signed(a) < $signed(b));
      else       lt = (a < b);
      return op[1] ? ~lt : lt;
   endfunction

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
      end
   endtask

   task automatic chk_outputs_zero(input string pfx);
      chk({pfx, "_req0_ready"},   64'(bus.req0_ready),   64'd0);
      chk({pfx, "_req1_ready"},   64'(bus.req1_ready),   64'd0);
      chk({pfx, "_resp0_valid"},  64'(bus.resp0_valid),  64'd0);
      chk({pfx, "_resp1_valid"},  64'(bus.resp1_valid),  64'd0);
      chk({pfx, "_resp0_result"}, 64'(bus.resp0_result), 64'd0);
      chk({pfx, "_resp1_result"}, 64'(bus.resp1_result), 64'd0);
      chk({pfx, "_resp0_tag"},    64'(bus.resp0_tag),    64'd0);
      chk({pfx, "_resp1_tag"},    64'(bus.resp1_tag),    64'd0);
   endtask

   task automatic set_req(input int p, input logic v, input logic [63:0] a, input logic [63:0] b,
                          input logic [1:0] op, input logic [3:0] tag);
      if (p == 0) begin
         bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op; bus.req0_tag = tag;
      end else begin
         bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op; bus.req1_tag = tag;
      end
   endtask

   task automatic check_port(input int p, input logic v, input logic rdy, input logic res, input logic [3:0] tg);
      int   n;
      exp_t e;
      n = (p != 0) ? q1.size() : q0.size();
      if (v) begin
         chk($sformatf("resp%0d_pending", p), 64'(n != 0), 64'd1);
         if (n != 0) begin
            e = (p != 0) ? q1[0] : q0[0];
            if (!pv[p]) begin
               chk($sformatf("resp%0d_latency", p), 64'(cyc - e.acc), 64'd2);
            end else begin
               chk($sformatf("resp%0d_stable_res", p), 64'(res), 64'(pres[p]));
               chk($sformatf("resp%0d_stable_tag", p), 64'(tg), 64'(ptag[p]));
            end
            if (rdy) begin
               chk($sformatf("resp%0d_result", p), 64'(res), 64'(e.res));
               chk($sformatf("resp%0d_tag", p), 64'(tg), 64'(e.tag));
               if (p != 0) void'(q1.pop_front());
               else        void'(q0.pop_front());
            end
         end
      end else begin
         chk($sformatf("resp%0d_idle_zero", p), 64'({res, tg}), 64'd0);
      end
      pv[p]   = v && !rdy;
      pres[p] = res;
      ptag[p] = tg;
   endtask

   // Called at a falling edge with inputs already driven; returns at the next falling edge.
   task automatic cycle();
      #1;
      acc0 = bus.req0_valid && bus.req0_ready;
      acc1 = bus.req1_valid && bus.req1_ready;
      chk("single_grant", 64'(bus.req0_ready & bus.req1_ready), 64'd0);
      if (acc0) q0.push_back('{model(bus.req0_a, bus.req0_b, bus.req0_op), bus.req0_tag, cyc});
      if (acc1) q1.push_back('{model(bus.req1_a, bus.req1_b, bus.req1_op), bus.req1_tag, cyc});
      check_port(0, bus.resp0_valid, bus.resp0_ready, bus.resp0_result, bus.resp0_tag);
      check_port(1, bus.resp1_valid, bus.resp1_ready, bus.resp1_result, bus.resp1_tag);
      cyc++;
      @(negedge clk);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((q0.size() + q1.size()) != 0 && n < 30) begin
         cycle();
         n++;
      end
      chk("drain", 64'(q0.size() + q1.size()), 64'd0);
   endtask

   task automatic do_op(input int p, input logic [63:0] a, input logic [63:0] b,
                        input logic [1:0] op, input logic [3:0] tag, output int waited);
      logic got;
      set_req(p, 1'b1, a, b, op, tag);
      waited = 0;
      got    = 1'b0;
      while (!got && waited < 20) begin
         cycle();
         waited++;
         got = (p != 0) ? acc1 : acc0;
      end
      set_req(p, 1'b0, '0, '0, 2'b00, 4'h0);
      chk($sformatf("accept%0d", p), 64'(got), 64'd1);
      drain();
   endtask

   initial begin
      int   w;
      int   ng;
      logic exp_g;

      tests = 0; fails = 0; cyc = 0;
      acc0 = 1'b0; acc1 = 1'b0;
      pv[0] = 1'b0; pv[1] = 1'b0;
      pres[0] = 1'b0; pres[1] = 1'b0;
      ptag[0] = 4'h0; ptag[1] = 4'h0;
      rst = 1'b1;
      set_req(0, 1'b0, '0, '0, 2'b00, 4'h0);
      set_req(1, 1'b0, '0, '0, 2'b00, 4'h0);
      bus.resp0_ready = 1'b1;
      bus.resp1_ready = 1'b1;

      @(negedge clk);
      @(negedge clk);
      #1;
      chk_outputs_zero("reset");
      @(negedge clk);
      rst = 1'b0;

      // Port 0 alone, first-cycle accept and two-cycle latency
      do_op(0, 64'd5, 64'd7, CMP_LTU, 4'd3, w);
      chk("t1_first_cycle_accept", 64'(w), 64'd1);

      // Signed versus unsigned on port 1
      do_op(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, CMP_LT,  4'd1, w);
      do_op(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, CMP_LTU, 4'd2, w);
      do_op(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, CMP_GE,  4'd4, w);
      do_op(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, CMP_GEU, 4'd5, w);
      do_op(1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, CMP_GE, 4'd6, w);
      do_op(0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, CMP_LTU, 4'd7, w);

      // Contention straight after reset: strict alternation from port 0
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      set_req(0, 1'b1, 64'd1, 64'd9, CMP_LTU, 4'd8);
      set_req(1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFB, 64'd2, CMP_LT, 4'd9);
      exp_g = 1'b0;
      ng    = 0;
      for (int i = 0; i < 20 && ng < 4; i++) begin
         cycle();
         if (acc0 || acc1) begin
            chk("rr_order", 64'(acc1), 64'(exp_g));
            exp_g = ~exp_g;
            ng++;
            if (acc0) set_req(0, 1'b1, 64'(ng * 11), 64'd20, 2'(ng), 4'(ng));
            else      set_req(1, 1'b1, 64'hFFFF_FFFF_FFFF_FF00, 64'(ng), 2'(3 - ng), 4'(ng + 10));
         end
      end
      chk("rr_grant_count", 64'(ng), 64'd4);
      set_req(0, 1'b0, '0, '0, 2'b00, 4'h0);
      set_req(1, 1'b0, '0, '0, 2'b00, 4'h0);
      drain();

      // Backpressure on port 0 while port 1 waits
      bus.resp0_ready = 1'b0;
      set_req(0, 1'b1, 64'd100, 64'd3, CMP_GEU, 4'hA);
      w = 0;
      acc0 = 1'b0;
      while (!acc0 && w < 20) begin
         cycle();
         w++;
      end
      chk("bp_accept0", 64'(acc0), 64'd1);
      set_req(0, 1'b0, '0, '0, 2'b00, 4'h0);
      set_req(1, 1'b1, 64'd3, 64'd100, CMP_LTU, 4'hB);
      for (int i = 0; i < 12; i++) begin
         cycle();
         chk("bp_req1_blocked", 64'(acc1), 64'd0);
      end
      bus.resp0_ready = 1'b1;
      cycle();
      cycle();
      chk("bp_p1_grant", 64'(acc1), 64'd1);
      set_req(1, 1'b0, '0, '0, 2'b00, 4'h0);
      drain();

      // Reset while the op sits in CMP: no response, pointer restored
      set_req(0, 1'b1, 64'd1, 64'd2, CMP_LTU, 4'hC);
      cycle();
      chk("rst_cmp_accept", 64'(acc0), 64'd1);
      set_req(0, 1'b0, '0, '0, 2'b00, 4'h0);
      rst = 1'b1;
      q0.delete();
      pv[0] = 1'b0; pv[1] = 1'b0;
      #1;
      chk_outputs_zero("rst_cmp");
      @(negedge clk);
      cycle();
      cycle();
      rst = 1'b0;
      set_req(0, 1'b1, 64'd40, 64'd30, CMP_GE, 4'hD);
      set_req(1, 1'b1, 64'd30, 64'd40, CMP_GE, 4'hE);
      cycle();
      chk("rst_ptr_grant0", 64'(acc0), 64'd1);
      chk("rst_ptr_no_grant1", 64'(acc1), 64'd0);
      set_req(0, 1'b0, '0, '0, 2'b00, 4'h0);
      set_req(1, 1'b0, '0, '0, 2'b00, 4'h0);
      drain();

      // Port 0 withdraws while port 1 holds the grant
      set_req(0, 1'b1, 64'd9, 64'd8, CMP_GEU, 4'h1);
      set_req(1, 1'b1, 64'd8, 64'd9, CMP_LTU, 4'h2);
      cycle();
      chk("wd_grant1", 64'(acc1), 64'd1);
      chk("wd_no_grant0", 64'(acc0), 64'd0);
      set_req(0, 1'b0, '0, '0, 2'b00, 4'h0);
      set_req(1, 1'b0, '0, '0, 2'b00, 4'h0);
      drain();
      for (int i = 0; i < 3; i++) cycle();
      chk("wd_no_resp0", 64'(q0.size()), 64'd0);
      do_op(0, 64'd2, 64'd2, CMP_GEU, 4'hF, w);
      chk("wd_idle_accept", 64'(w), 64'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
